serial_adder: RTL

- Bit-serial adder: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, through a single full-adder cell with a registered carry.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits directly downstream of the operand source and wraps the team's 1-bit full adder as its datapath; trades latency for area against a ripple adder.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 89 ++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Operand and result handshakes for the bit-serial adder.
// The master side is the operand source / result consumer; the slave side is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, s, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, s, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry, LSB first,
// producing {c_out, s} = a + b + c_in after WIDTH clock cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus,
  output logic          busy
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               ready_en;
  logic [1:0]         fa;
  logic               last_bit;

  // Team 1-bit full adder: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign fa       = full_add(a_sh[0], b_sh[0], carry);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // in_ready comes from registered state only; ready_en keeps it low until
  // the first edge after reset release.
  assign bus.in_ready  = (state == IDLE) && ready_en;
  assign bus.out_valid = (state == DONE);
  assign busy          = (state == ADD) || (state == DONE);
  assign bus.s         = sum_sh;
  assign bus.c_out     = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid && bus.in_ready) state_nxt = ADD;
      ADD:     if (last_bit) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.c_in;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        ADD: begin
          // Sum bits enter at the MSB and walk down to their final position.
          sum_sh <= {fa[0], sum_sh[WIDTH-1:1]};
          carry  <= fa[1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
